// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operand_b operation codes and default datapath width,
// used by both the control FSM and the accumulator/ALU stage.
package cpu_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic [1:0] OPB_ARITH    = 2'b00;
    localparam logic [1:0] OPB_LOAD_INC = 2'b01;
    localparam logic [1:0] OPB_SHL      = 2'b10;
    localparam logic [1:0] OPB_HOLD     = 2'b11;

endpackage

// File: rtl/cpu_adder.sv
// Combinational WIDTH-bit adder with optional inversion of b and a carry-in.
// Serves add, subtract (invert_b=1, cin=1) and increment (b=0, cin=1).
module cpu_adder #(
    parameter int WIDTH = cpu_pkg::DATA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             invert_b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    assign b_eff       = invert_b ? ~b : b;
    assign full        = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    assign sum         = full[WIDTH-1:0];
    assign cout        = full[WIDTH];

endmodule

// File: rtl/cpu_acc_alu.sv
// Accumulator/ALU stage downstream of the CPU control FSM.
// Optional sticky signed-overflow flag enabled by defining CPU_ACC_OVF_EN.
module cpu_acc_alu
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [1:0]       operand_b,
    input  logic             en_acc,
    input  logic             clr_acc,
    input  logic             carry_en,
    input  logic             substrate,
    input  logic             carry_flag,
    input  logic             wr_e,
    output logic             carry_f_in,
    output logic             zero,
`ifdef CPU_ACC_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] data_out,
    output logic             data_out_en
);

    logic [WIDTH-1:0] add_b;
    logic             add_inv;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] res;
    logic             co;
    logic [WIDTH-1:0] acc_next;

    cpu_adder #(.WIDTH(WIDTH)) u_adder (
        .a        (acc),
        .b        (add_b),
        .invert_b (add_inv),
        .cin      (add_cin),
        .sum      (add_sum),
        .cout     (add_cout)
    );

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        add_b   = operand_a;
        add_inv = 1'b0;
        add_cin = 1'b0;
        res     = acc;
        co      = 1'b0;
        unique case (operand_b)
            OPB_ARITH: begin
                add_inv = substrate;
                add_cin = substrate ? 1'b1 : (carry_en & carry_flag);
                res     = add_sum;
                co      = add_cout;
            end
            OPB_LOAD_INC: begin
                if (carry_en) begin
                    add_b   = '0;
                    add_cin = 1'b1;
                    res     = add_sum;
                    co      = add_cout;
                end else begin
                    res = operand_a;
                end
            end
            OPB_SHL: begin
                res = {acc[WIDTH-2:0], 1'b0};
                co  = acc[WIDTH-1];
            end
            default: begin
                res = acc;
                co  = 1'b0;
            end
        endcase
    end

    assign acc_next    = clr_acc ? '0 : (en_acc ? res : acc);
    assign carry_f_in  = co;
    assign data_out    = wr_e ? acc : '0;
    assign data_out_en = wr_e;

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            zero <= 1'b1;
        end else begin
            acc  <= acc_next;
            zero <= (acc_next == '0);
        end
    end

`ifdef CPU_ACC_OVF_EN
    logic b_sign;
    logic ovf_set;

    // Subtract compares against the sign of ~operand_a, the value the adder actually sees.
    assign b_sign  = substrate ? ~operand_a[WIDTH-1] : operand_a[WIDTH-1];
    assign ovf_set = en_acc && (operand_b == OPB_ARITH)
                     && (acc[WIDTH-1] == b_sign) && (res[WIDTH-1] != acc[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst || clr_acc) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_acc_alu.sv
// Self-checking bench for cpu_acc_alu: directed scenarios plus random stimulus
// against an integer-arithmetic reference model.
module tb_cpu_acc_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] operand_a;
    logic [1:0] operand_b;
    logic       en_acc, clr_acc, carry_en, substrate, carry_flag, wr_e;
    logic       carry_f_in, zero, data_out_en;
    logic [7:0] acc, data_out;
`ifdef CPU_ACC_OVF_EN
    logic       ovf;
`endif

    int tests  = 0;
    int failed = 0;
    int m_acc  = 0;
    int m_ovf  = 0;

    always #5 clk = ~clk;

    cpu_acc_alu #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .en_acc      (en_acc),
        .clr_acc     (clr_acc),
        .carry_en    (carry_en),
        .substrate   (substrate),
        .carry_flag  (carry_flag),
        .wr_e        (wr_e),
        .carry_f_in  (carry_f_in),
        .zero        (zero),
`ifdef CPU_ACC_OVF_EN
        .ovf         (ovf),
`endif
        .acc         (acc),
        .data_out    (data_out),
        .data_out_en (data_out_en)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Reference: plain integer arithmetic on the unsigned/signed values.
    task automatic model(input int opb, input int a, input int ce, input int sub, input int cf,
                         output int res, output int co, output int ov);
        int s;
        ov = 0;
        res = m_acc;
        co = 0;
        case (opb)
            0: begin
                if (sub != 0) begin
                    res = (m_acc - a + 256) % 256;
                    co  = (m_acc >= a) ? 1 : 0;
                    s   = sgn(m_acc) - sgn(a);
                end else begin
                    s   = m_acc + a + ((ce != 0) ? cf : 0);
                    res = s % 256;
                    co  = (s > 255) ? 1 : 0;
                    s   = sgn(m_acc) + sgn(a) + ((ce != 0) ? cf : 0);
                end
                ov = (s < -128 || s > 127) ? 1 : 0;
            end
            1: begin
                if (ce != 0) begin
                    res = (m_acc + 1) % 256;
                    co  = (m_acc == 255) ? 1 : 0;
                end else begin
                    res = a;
                end
            end
            2: begin
                res = (m_acc * 2) % 256;
                co  = (m_acc >= 128) ? 1 : 0;
            end
            default: ;
        endcase
    endtask

    task automatic step(input int r, input int opb, input int a, input int en, input int clr,
                        input int ce, input int sub, input int cf, input int we);
        int res, co, ov;
        @(negedge clk);
        rst        = (r != 0);
        operand_b  = opb[1:0];
        operand_a  = a[7:0];
        en_acc     = (en != 0);
        clr_acc    = (clr != 0);
        carry_en   = (ce != 0);
        substrate  = (sub != 0);
        carry_flag = (cf != 0);
        wr_e       = (we != 0);
        #1;
        model(opb, a, ce, sub, cf, res, co, ov);
        check("carry_f_in", carry_f_in, co);
        check("data_out", data_out, (we != 0) ? m_acc : 0);
        check("data_out_en", data_out_en, we);
        if (r != 0) begin
            m_acc = 0;
            m_ovf = 0;
        end else if (clr != 0) begin
            m_acc = 0;
            m_ovf = 0;
        end else if (en != 0) begin
            m_acc = res;
            if (opb == 0 && ov != 0) m_ovf = 1;
        end
        @(posedge clk);
        #1;
        check("acc", acc, m_acc);
        check("zero", zero, (m_acc == 0) ? 1 : 0);
`ifdef CPU_ACC_OVF_EN
        check("ovf", ovf, m_ovf);
`endif
    endtask

    task automatic load(input int v);
        step(0, 1, v, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset held two cycles, hold operation selected.
        step(1, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0, 0, 0);
        // Load then add to wrap to zero with carry out.
        load(8'h5A);
        step(0, 0, 8'hA6, 1, 0, 0, 0, 0, 0);
        // Add with and without carry-in.
        load(8'h10);
        step(0, 0, 8'h01, 1, 0, 1, 0, 1, 0);
        load(8'h10);
        step(0, 0, 8'h01, 1, 0, 0, 0, 1, 0);
        // Subtract with borrow, then to zero.
        load(8'h05);
        step(0, 0, 8'h07, 1, 0, 0, 1, 1, 0);
        load(8'h05);
        step(0, 0, 8'h05, 1, 0, 0, 1, 0, 0);
        // Shift out the top bit; increment wrap.
        load(8'h81);
        step(0, 2, 0, 1, 0, 0, 0, 0, 0);
        load(8'hFF);
        step(0, 1, 0, 1, 0, 1, 0, 0, 0);
        // Clear beats enable; store shows current acc; store with update shows old acc.
        load(8'h44);
        step(0, 1, 8'h33, 1, 1, 0, 0, 0, 0);
        load(8'h3C);
        step(0, 3, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 8'h99, 1, 0, 0, 0, 0, 1);
        // Reset discards an in-flight load.
        step(1, 1, 8'h55, 1, 0, 0, 0, 0, 0);
        // Signed overflow, sticky until clear.
        load(8'h7F);
        step(0, 0, 8'h01, 1, 0, 0, 0, 0, 0);
        step(0, 3, 0, 0, 0, 0, 0, 0, 0);
        load(8'h01);
        step(0, 0, 8'h00, 0, 1, 0, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 31) == 0) ? 1 : 0,
                 $urandom_range(0, 3),
                 $urandom_range(0, 255),
                 ($urandom_range(0, 3) != 0) ? 1 : 0,
                 ($urandom_range(0, 7) == 0) ? 1 : 0,
                 $urandom_range(0, 1),
                 $urandom_range(0, 1),
                 $urandom_range(0, 1),
                 $urandom_range(0, 1));
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
